// File: rtl/addr_sched.sv
// addr_sched: address-logic scheduler.
//
// Arbitrates jump, data and fetch requests, drives the one-hot select to the
// address adder, the PC load enable, the address-valid qualifier and the
// single-cycle completion pulses. Every output is decoded from the registered
// state, plus the data mode latched at the data grant.
//
// Ports
//   clk        in   single clock, rising edge
//   ResetN     in   asynchronous active-low reset
//   FetchReq   in   instruction-fetch request, held until FetchAck
//   JumpReq    in   relative-jump request, held until JumpAck
//   DataReq    in   data-access request, held until DataAck
//   DataMode   in   1 = R+I, 0 = R+0; sampled at data grant
//   MemReady   in   memory completes the current access this cycle
//   ResetPC, PCplusI, PCplus1, RplusI, Rplus0
//              out  one-hot address select; all low = PC pass-through
//   EnablePC   out  load PC from address-logic output
//   AddrValid  out  address-logic output is a valid memory address
//   FetchAck, JumpAck, DataAck
//              out  single-cycle completion pulses
//   Busy       out  high in every state except IDLE
module addr_sched #(
  parameter int unsigned STREAK_MAX = 3
) (
  input  logic clk,
  input  logic ResetN,
  input  logic FetchReq,
  input  logic JumpReq,
  input  logic DataReq,
  input  logic DataMode,
  input  logic MemReady,
  output logic ResetPC,
  output logic PCplusI,
  output logic PCplus1,
  output logic RplusI,
  output logic Rplus0,
  output logic EnablePC,
  output logic AddrValid,
  output logic FetchAck,
  output logic JumpAck,
  output logic DataAck,
  output logic Busy
);

  typedef enum logic [2:0] {
    RSTPC,
    IDLE,
    JUMP,
    FETCH,
    INC,
    DATA,
    DACK
  } state_t;

  localparam logic [2:0] SMAX = 3'(STREAK_MAX);

  state_t     state, nstate;
  logic [2:0] streak, streak_nx;
  logic       mode, mode_nx;
  logic       fetch_wins;

  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      state  <= RSTPC;
      streak <= '0;
      mode   <= 1'b0;
    end else begin
      state  <= nstate;
      streak <= streak_nx;
      mode   <= mode_nx;
    end
  end

  // A pending fetch overtakes data once data has won STREAK_MAX times in a row.
  assign fetch_wins = FetchReq && (streak == SMAX);

  always_comb begin
    nstate    = state;
    streak_nx = streak;
    mode_nx   = mode;
    case (state)
      RSTPC: nstate = IDLE;
      IDLE: begin
        if (JumpReq) begin
          nstate = JUMP;
        end else if (DataReq && !fetch_wins) begin
          nstate  = DATA;
          mode_nx = DataMode;
          if (streak < SMAX) begin
            streak_nx = streak + 3'd1;
          end
        end else if (FetchReq) begin
          nstate    = FETCH;
          streak_nx = '0;
        end
      end
      JUMP:  nstate = IDLE;
      FETCH: if (MemReady) nstate = INC;
      INC:   nstate = IDLE;
      DATA:  if (MemReady) nstate = DACK;
      DACK:  nstate = IDLE;
      default: nstate = RSTPC;
    endcase
  end

  always_comb begin
    ResetPC   = 1'b0;
    PCplusI   = 1'b0;
    PCplus1   = 1'b0;
    RplusI    = 1'b0;
    Rplus0    = 1'b0;
    EnablePC  = 1'b0;
    AddrValid = 1'b0;
    FetchAck  = 1'b0;
    JumpAck   = 1'b0;
    DataAck   = 1'b0;
    Busy      = (state != IDLE);
    case (state)
      RSTPC: begin
        ResetPC  = 1'b1;
        EnablePC = 1'b1;
      end
      JUMP: begin
        PCplusI  = 1'b1;
        EnablePC = 1'b1;
        JumpAck  = 1'b1;
      end
      FETCH: AddrValid = 1'b1;
      INC: begin
        PCplus1  = 1'b1;
        EnablePC = 1'b1;
        FetchAck = 1'b1;
      end
      DATA: begin
        AddrValid = 1'b1;
        RplusI    = mode;
        Rplus0    = !mode;
      end
      DACK: DataAck = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_addr_sched.sv
// tb_addr_sched: self-checking bench for addr_sched.
// Transactions are scored against a request-level model: the winner is chosen
// from the priority rules and a streak count, and each transaction's expected
// output trace follows from the kind of service granted.
module tb_addr_sched;

  localparam int unsigned SM = 3;

  // Output vector layout:
  // {ResetPC,PCplusI,PCplus1,RplusI,Rplus0,EnablePC,AddrValid,FetchAck,JumpAck,DataAck,Busy}
  localparam logic [10:0] V_RST   = 11'b10000100001;
  localparam logic [10:0] V_IDLE  = 11'b00000000000;
  localparam logic [10:0] V_JUMP  = 11'b01000100101;
  localparam logic [10:0] V_FETCH = 11'b00000010001;
  localparam logic [10:0] V_INC   = 11'b00100101001;
  localparam logic [10:0] V_DATA1 = 11'b00010010001;
  localparam logic [10:0] V_DATA0 = 11'b00001010001;
  localparam logic [10:0] V_DACK  = 11'b00000000011;

  logic clk, ResetN, FetchReq, JumpReq, DataReq, DataMode, MemReady;
  logic ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC, AddrValid;
  logic FetchAck, JumpAck, DataAck, Busy;
  logic [10:0] obs;

  int n_chk = 0;
  int n_fail = 0;
  int streak_m = 0;

  addr_sched #(.STREAK_MAX(SM)) dut (
    .clk(clk), .ResetN(ResetN), .FetchReq(FetchReq), .JumpReq(JumpReq),
    .DataReq(DataReq), .DataMode(DataMode), .MemReady(MemReady),
    .ResetPC(ResetPC), .PCplusI(PCplusI), .PCplus1(PCplus1), .RplusI(RplusI),
    .Rplus0(Rplus0), .EnablePC(EnablePC), .AddrValid(AddrValid),
    .FetchAck(FetchAck), .JumpAck(JumpAck), .DataAck(DataAck), .Busy(Busy)
  );

  assign obs = {ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC,
                AddrValid, FetchAck, JumpAck, DataAck, Busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input string tag, input logic [10:0] e);
    check(tag, 32'(obs), 32'(e));
    check({tag, "_onehot"},
          32'($countones({ResetPC, PCplusI, PCplus1, RplusI, Rplus0}) <= 1), 32'd1);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic byte winner(input bit j, input bit d, input bit f, input int s);
    if (j) return "J";
    if (d && !(f && s == int'(SM))) return "D";
    if (f) return "F";
    return "N";
  endfunction

  function automatic byte observed_kind();
    if (PCplusI) return "J";
    if (AddrValid && (RplusI || Rplus0)) return "D";
    if (AddrValid) return "F";
    return "N";
  endfunction

  // One request set presented in IDLE, followed through to IDLE again.
  // dly = number of wait cycles with MemReady low before it is raised.
  task automatic txn(input bit j, input bit d, input bit f, input bit m,
                     input int dly, output byte g);
    byte exp_k;
    JumpReq  = j;
    DataReq  = d;
    FetchReq = f;
    DataMode = m;
    MemReady = 1'($urandom % 2);    // ignored in IDLE
    exp_k = winner(j, d, f, streak_m);
    tick;
    g = observed_kind();
    case (exp_k)
      "N": sample("idle_hold", V_IDLE);
      "J": begin
        sample("jump", V_JUMP);
        JumpReq = 1'b0;
        tick;
        sample("jump_idle", V_IDLE);
      end
      "F": begin
        streak_m = 0;
        for (int w = 0; w <= dly; w++) begin
          sample("fetch_wait", V_FETCH);
          MemReady = (w == dly);
          JumpReq  = 1'($urandom % 2);  // not sampled outside IDLE
          tick;
        end
        sample("fetch_inc", V_INC);
        FetchReq = 1'b0;
        JumpReq  = 1'b0;
        MemReady = 1'b0;
        tick;
        sample("fetch_idle", V_IDLE);
      end
      default: begin
        if (streak_m < int'(SM)) streak_m++;
        for (int w = 0; w <= dly; w++) begin
          sample("data_wait", m ? V_DATA1 : V_DATA0);
          MemReady = (w == dly);
          DataMode = ~DataMode;
          JumpReq  = 1'($urandom % 2);
          tick;
        end
        sample("data_ack", V_DACK);
        DataReq  = 1'b0;
        JumpReq  = 1'b0;
        MemReady = 1'b0;
        tick;
        sample("data_idle", V_IDLE);
      end
    endcase
  endtask

  initial begin
    byte g;
    byte exp_ord[8];
    exp_ord = '{"D", "D", "D", "F", "D", "D", "D", "F"};

    ResetN = 1'b0;
    FetchReq = 1'b0;
    JumpReq = 1'b0;
    DataReq = 1'b0;
    DataMode = 1'b0;
    MemReady = 1'b0;
    tick;
    tick;
    sample("in_reset", V_RST);
    ResetN = 1'b1;
    sample("rstpc_cycle", V_RST);
    tick;
    sample("post_reset_idle", V_IDLE);

    // Fetch with MemReady three cycles late.
    txn(1'b0, 1'b0, 1'b1, 1'b0, 3, g);
    check("fetch_grant", 32'(g), 32'("F"));

    // Jump beats a simultaneous fetch; fetch is served next.
    txn(1'b1, 1'b0, 1'b1, 1'b0, 0, g);
    check("prio_jump", 32'(g), 32'("J"));
    txn(1'b0, 1'b0, 1'b1, 1'b0, 1, g);
    check("fetch_after_jump", 32'(g), 32'("F"));

    // Data in R+I mode with the mode input toggling during the wait.
    txn(1'b0, 1'b1, 1'b0, 1'b1, 2, g);
    check("data_modei", 32'(g), 32'("D"));
    txn(1'b0, 1'b1, 1'b0, 1'b0, 0, g);
    check("data_mode0", 32'(g), 32'("D"));

    // Reset in the middle of a data wait: no ack, streak forgotten.
    DataReq  = 1'b1;
    DataMode = 1'b1;
    tick;
    sample("pre_abort_data", V_DATA1);
    tick;
    sample("pre_abort_data2", V_DATA1);
    MemReady = 1'b1;
    #2;
    ResetN = 1'b0;
    #1;
    sample("abort_async", V_RST);
    tick;
    sample("abort_held", V_RST);
    ResetN   = 1'b0;
    DataReq  = 1'b0;
    MemReady = 1'b0;
    ResetN   = 1'b1;
    sample("abort_release", V_RST);
    tick;
    sample("abort_idle", V_IDLE);
    streak_m = 0;

    // Data and fetch both pending continuously.
    for (int i = 0; i < 8; i++) begin
      txn(1'b0, 1'b1, 1'b1, 1'($urandom % 2), int'($urandom_range(0, 2)), g);
      check($sformatf("order_%0d", i), 32'(g), 32'(exp_ord[i]));
    end

    // Random request mixes.
    for (int i = 0; i < 300; i++) begin
      bit j, d, f;
      byte e;
      j = ($urandom % 4) == 0;
      d = 1'($urandom % 2);
      f = 1'($urandom % 2);
      e = winner(j, d, f, streak_m);
      txn(j, d, f, 1'($urandom % 2), int'($urandom_range(0, 3)), g);
      check("rand_grant", 32'(g), 32'(e));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_sched.md
ADDR_SCHED -- requirements
Module: addr_sched

Interface
REQ-001 Parameter: STREAK_MAX, 3, consecutive data grants (1..7) after which a pending fetch beats data.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 ResetN  in  1  asynchronous, active-low reset.
REQ-004 FetchReq  in  1  instruction-fetch request; held high until FetchAck.
REQ-005 JumpReq  in  1  relative-jump request (PC <- PC+I); held high until JumpAck.
REQ-006 DataReq  in  1  data-access request; held high until DataAck.
REQ-007 DataMode  in  1  1 = address R+I, 0 = address R+0; sampled at data grant.
REQ-008 MemReady  in  1  memory completes current access this cycle.
REQ-009 ResetPC, PCplusI, PCplus1, RplusI, Rplus0  out  1 each  one-hot select to address logic; all low selects PC pass-through.
REQ-010 EnablePC  out  1  load PC register from address-logic output.
REQ-011 AddrValid  out  1  address-logic output is a valid memory address.
REQ-012 FetchAck, JumpAck, DataAck  out  1 each  single-cycle completion pulses.
REQ-013 Busy  out  1  high in every state except IDLE.

Function
REQ-014 Moore FSM states: RSTPC, IDLE, JUMP, FETCH, INC, DATA, DACK; all outputs decoded from registered state (and latched mode) only.
REQ-015 At most one of the five select outputs SHALL be high in any cycle.
REQ-016 RSTPC: ResetPC=1, EnablePC=1, other outputs 0; next state IDLE unconditionally.
REQ-017 IDLE: all outputs 0; grant priority JumpReq > DataReq > FetchReq, except FetchReq beats DataReq when streak counter == STREAK_MAX.
REQ-018 JUMP (one cycle): PCplusI=1, EnablePC=1, JumpAck=1; next IDLE.
REQ-019 FETCH: all selects 0, AddrValid=1; stay until MemReady sampled high, then INC.
REQ-020 INC (one cycle): PCplus1=1, EnablePC=1, FetchAck=1; next IDLE.
REQ-021 DATA: AddrValid=1, RplusI=1 if latched mode 1 else Rplus0=1; EnablePC=0; stay until MemReady high, then DACK.
REQ-022 DACK (one cycle): DataAck=1, selects 0; next IDLE.
REQ-023 DataMode latched on the IDLE->DATA edge; changes during DATA ignored.
REQ-024 Requests and MemReady sampled only in IDLE / FETCH / DATA respectively; ignored elsewhere.
REQ-025 Streak counter (3 bits): +1 on each data grant, saturating at STREAK_MAX; cleared on each fetch grant; unchanged on jump grant.
REQ-026 Latency: jump ack 1 cycle after IDLE grant edge; fetch/data ack minimum 2 cycles after grant (MemReady high in first wait cycle).
REQ-027 A request dropped by its requester before grant is never served; no ack issued.
REQ-028 MemReady never arriving holds FETCH/DATA indefinitely (no timeout).

Reset
REQ-029 ResetN low SHALL immediately force state RSTPC, streak 0, latched mode 0, regardless of clock.
REQ-030 During reset: ResetPC=1, EnablePC=1, Busy=1, AddrValid=0, all acks 0.
REQ-031 First rising edge after ResetN rises: RSTPC cycle completes (PC cleared), then IDLE.
REQ-032 Reset mid-FETCH/DATA aborts the access with no ack; requester re-issues after reset.

Verification
REQ-033 Release reset, no requests -> one cycle ResetPC=1/EnablePC=1, then IDLE, Busy=0, all selects 0.
REQ-034 FetchReq=1, MemReady delayed 3 cycles -> AddrValid high 4 cycles with selects 0, then INC: PCplus1=1, EnablePC=1, FetchAck=1 for exactly one cycle.
REQ-035 JumpReq and FetchReq both high in IDLE -> JUMP first (PCplusI, JumpAck), then fetch served; never two selects high.
REQ-036 DataReq with DataMode=1, mode flipped to 0 mid-wait, MemReady=1 -> RplusI held throughout, DataAck one pulse, EnablePC stays 0.
REQ-037 DataReq and FetchReq continuously high, STREAK_MAX=3 -> grant order D,D,D,F,D,D,D,F.
REQ-038 ResetN low during DATA wait -> immediate ResetPC=1, no DataAck, streak 0 after release.
